// File: rtl/pol_rd_arb.sv
// pol_rd_arb
// Shares the single GLB pooling-read port among POOL_CORE pooling cores.
// Each cycle one requesting core is picked round-robin and its address is
// forwarded to the GLB. The winner's index is pushed into a tag FIFO so
// that GLB responses, which come back in order, are steered to the core
// that issued the matching address.
//
// Ports
//   clk              clock
//   rst_n            asynchronous reset, active-high (1 = in reset)
//   POLARB_Rst       synchronous clear of the tag FIFO and rr pointer
//   PLCARB_AddrVld   per-core address request
//   PLCARB_Addr      per-core address, core i at [IDX_WIDTH*i +: IDX_WIDTH]
//   ARBPLC_AddrRdy   per-core accept, one-hot at the current winner
//   ARBGLB_AddrVld   address valid towards the GLB
//   ARBGLB_Addr      granted address (0 when nothing is requested)
//   GLBARB_AddrRdy   GLB accepts the address
//   GLBARB_Ofm       OFM word returned by the GLB
//   GLBARB_OfmVld    returned word valid
//   ARBGLB_OfmRdy    block accepts the returned word
//   ARBPLC_Ofm       returned word broadcast to all cores
//   ARBPLC_OfmVld    one-hot valid to the core owning the head tag
//   PLCARB_OfmRdy    per-core ready for returned words
//   ARBPOL_Idle      no reads outstanding
module pol_rd_arb #(
  parameter int POOL_CORE      = 6,
  parameter int IDX_WIDTH      = 10,
  parameter int ACT_WIDTH      = 8,
  parameter int POOL_COMP_CORE = 64,
  parameter int MAX_OUTSTD     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                POLARB_Rst,
  input  logic [POOL_CORE-1:0]                PLCARB_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]      PLCARB_Addr,
  output logic [POOL_CORE-1:0]                ARBPLC_AddrRdy,
  output logic                                ARBGLB_AddrVld,
  output logic [IDX_WIDTH-1:0]                ARBGLB_Addr,
  input  logic                                GLBARB_AddrRdy,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBARB_Ofm,
  input  logic                                GLBARB_OfmVld,
  output logic                                ARBGLB_OfmRdy,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] ARBPLC_Ofm,
  output logic [POOL_CORE-1:0]                ARBPLC_OfmVld,
  input  logic [POOL_CORE-1:0]                PLCARB_OfmRdy,
  output logic                                ARBPOL_Idle
);

  localparam int PTR_W   = $clog2(POOL_CORE);
  localparam int FIFO_AW = $clog2(MAX_OUTSTD);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [PTR_W:0]   NCORE    = (PTR_W+1)'(POOL_CORE);
  localparam logic [PTR_W-1:0] LASTCORE = PTR_W'(POOL_CORE - 1);
  localparam logic [CNT_W-1:0] FULLCNT  = CNT_W'(MAX_OUTSTD);

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   tagMem [MAX_OUTSTD];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               anyReq;
  logic [PTR_W-1:0]   winIdx;
  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   head;
  logic               push;
  logic               pop;

  assign full  = (count == FULLCNT);
  assign empty = (count == '0);
  assign head  = tagMem[rdPtr];

  // Round-robin search starting at rrPtr. cand is one bit wider than the
  // index so rrPtr+k can be folded back below POOL_CORE with one subtract,
  // which also works when POOL_CORE is not a power of two.
  always_comb begin
    anyReq = 1'b0;
    winIdx = '0;
    cand   = '0;
    for (int k = 0; k < POOL_CORE; k++) begin
      cand = {1'b0, rrPtr} + (PTR_W+1)'(k);
      if (cand >= NCORE) begin
        cand = cand - NCORE;
      end
      if (!anyReq && PLCARB_AddrVld[cand[PTR_W-1:0]]) begin
        anyReq = 1'b1;
        winIdx = cand[PTR_W-1:0];
      end
    end
  end

  // Address mux and per-core accept.
  always_comb begin
    ARBGLB_Addr    = '0;
    ARBPLC_AddrRdy = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (anyReq && (winIdx == PTR_W'(i))) begin
        ARBGLB_Addr       = PLCARB_Addr[i*IDX_WIDTH +: IDX_WIDTH];
        ARBPLC_AddrRdy[i] = GLBARB_AddrRdy & ~full;
      end
    end
  end

  assign ARBGLB_AddrVld = anyReq & ~full;

  // Response steering: the word goes to whichever core owns the oldest tag.
  always_comb begin
    ARBPLC_OfmVld = '0;
    if (GLBARB_OfmVld && !empty) begin
      ARBPLC_OfmVld[head] = 1'b1;
    end
  end

  assign ARBPLC_Ofm    = GLBARB_Ofm;
  assign ARBGLB_OfmRdy = ~empty & PLCARB_OfmRdy[head];
  assign ARBPOL_Idle   = empty;

  // ARBGLB_AddrVld already carries !full, so a pop in the same cycle can
  // never open a slot for a push; the freed slot is usable one cycle later.
  assign push = ARBGLB_AddrVld & GLBARB_AddrRdy;
  assign pop  = GLBARB_OfmVld & ARBGLB_OfmRdy;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rrPtr <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < MAX_OUTSTD; i++) begin
        tagMem[i] <= '0;
      end
    end else if (POLARB_Rst) begin
      rrPtr <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tagMem[wrPtr] <= winIdx;
        wrPtr         <= wrPtr + FIFO_AW'(1);
        rrPtr         <= (winIdx == LASTCORE) ? '0 : winIdx + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
